// File: rtl/traffic_timer.sv
// traffic_timer: loadable two-digit BCD down-counter that times one
// traffic-light phase and signals its expiry to the light controller.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   load  load strobe from the controller (captures data on the next edge)
//   data  phase duration in BCD, [7:4] tens, [3:0] ones
//   en    run enable; low freezes the prescaler and the count
//   cnt   remaining time in BCD (registered)
//   done  one-cycle expiry pulse, wired to the controller's cin (registered)
//   busy  high while an armed countdown is pending
//
// Parameters:
//   TICK_DIV  clk cycles per count tick (>= 2)
//   PW        prescaler width, 2**PW >= TICK_DIV
module traffic_timer #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned PW       = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  input  logic       en,
  output logic [7:0] cnt,
  output logic       done,
  output logic       busy
);

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre;
  logic          armed;
  logic          tick;
  logic [7:0]    data_sat;

  // Clamp a single BCD digit into 0..9 so cnt never holds a non-BCD value.
  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign data_sat = {clamp9(data[7:4]), clamp9(data[3:0])};

  // One count tick per TICK_DIV enabled cycles.
  assign tick = en && (pre == PRE_LAST);

  assign busy = armed;

  // Prescaler, count, armed flag and expiry pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre   <= '0;
      cnt   <= 8'h00;
      armed <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        // A load restarts the second boundary and swallows any coincident tick.
        cnt   <= data_sat;
        pre   <= '0;
        armed <= 1'b1;
      end else begin
        if (en) begin
          pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
        end
        if (tick && armed) begin
          // 01 and 00 both expire on this tick, so a loaded 00 fires on the first tick.
          if (cnt == 8'h01 || cnt == 8'h00) begin
            cnt   <= 8'h00;
            done  <= 1'b1;
            armed <= 1'b0;
          end else if (cnt[3:0] != 4'd0) begin
            cnt[3:0] <= cnt[3:0] - 4'd1;
          end else begin
            cnt <= {cnt[7:4] - 4'd1, 4'd9};
          end
        end
      end
    end
  end

endmodule

// File: doc/traffic_timer.md
Name: traffic_timer

Overview:
- Loadable two-digit BCD down-counter timing each traffic-light phase.
- Sits directly downstream of the light-sequencing controller: consumes its 8-bit BCD phase duration (`data`) and `load` strobe.
- Produces the phase-expired pulse that drives the controller's `cin` input, plus BCD digits for the countdown display.
- Contains its own clock prescaler so the count decrements once per second.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per count tick (1 s at 50 MHz); minimum 2; benches use 4.
- PW, 26, prescaler width; must satisfy 2^PW >= TICK_DIV.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  load strobe from controller, sampled each clk edge.
- data  input  8  phase duration in BCD: [7:4] tens, [3:0] ones.
- en  input  1  run enable; 0 pauses prescaler and count.
- cnt  output  8  current remaining time, BCD.
- done  output  1  one-cycle expiry pulse; connect to controller `cin`.
- busy  output  1  high while an armed countdown is pending.

Behaviour:
- Reset (async, rst=1): cnt=8'h00, done=0, busy=0, prescaler=0, armed=0. Reset mid-count abandons the count immediately. No done pulse after release until a new load.
- Registers: prescaler `pre`, count `cnt`, flag `armed`, pulse `done`. All outputs are registered; busy = armed.
- Tick: `tick` is internal and combinational.
  - tick = en & (pre == TICK_DIV-1).
  - Each cycle with en=1: pre <= (pre == TICK_DIV-1) ? 0 : pre+1.
  - en=0: pre holds.
- Load (highest priority after reset): on a clk edge with load=1:
  - cnt <= sanitised data.
  - pre <= 0.
  - armed <= 1.
  - done <= 0.
  - Load wins over a coincident tick; that tick is discarded.
  - Load is honoured regardless of en.
- Sanitising: any BCD digit > 9 is clamped to 9 (e.g. 8'hA3 loads 8'h93; 8'h3F loads 8'h39).
- Decrement: on tick with armed=1 and no load, apply the first matching case:
  - cnt == 8'h01 or cnt == 8'h00: cnt <= 8'h00, done <= 1, armed <= 0.
  - ones != 0: ones <= ones-1.
  - ones == 0: ones <= 9, tens <= tens-1.
- Result: a loaded value N (N >= 1) yields done exactly N ticks after load. A loaded 00 yields done at the first tick.
- Idle: on tick with armed=0, cnt holds 8'h00 and done stays 0. There is no repeated expiry and no wrap below 00.
- done is high for exactly one clk cycle, then returns to 0 on the next edge unless re-set.
- Handshake with controller:
  - done=1 causes the controller to assert load with the next phase's data in the same cycle.
  - The timer captures that data on the following edge.
  - The phase chain is self-sustaining with zero dead cycles.
- Pause: with en=0, cnt, pre and armed hold and no done is produced. Counting resumes from the held pre value.
- Width rules: all BCD arithmetic is per-nibble. cnt never holds a non-BCD value.

Test Plan:
- Use TICK_DIV=4 for all scenarios.
- Reset: assert rst mid-count with cnt=8'h17 -> cnt=8'h00, done=0, busy=0 asynchronously. After release, no done pulse within 20 cycles.
- Basic countdown: load data=8'h05, en=1 -> cnt steps 05,04,03,02,01,00 every 4 cycles. done pulses exactly once, in the tick cycle that reaches 00 (20 cycles after load). busy falls at the same time.
- Tens borrow: load 8'h30 -> after 1 tick cnt=8'h29; after 21 ticks cnt=8'h09. done occurs after tick 30.
- Load/tick collision and sanitising:
  - Assert load with 8'hA3 in the same cycle tick would fire -> cnt=8'h93, pre=0, no decrement, no done.
  - Load 8'h00 -> done pulses at the first tick.
- Pause: load 8'h03, drop en for 10 cycles after the first tick -> cnt holds 8'h02, no done. Re-raise en -> done arrives after 2 further ticks.
- Closed loop with controller (`cin`=done, data/load from controller) -> phase durations of 30, 30 and 5 ticks repeat. Each done is followed by load on the same cycle and by a new cnt on the next edge.
